// File: rtl/regfile_sched_pkg.sv
// Purpose : shared types and constants for the register-file write scheduler.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: grant_e (who owns the write port this cycle), state_e (arbiter
//           FSM state), REG_ZERO (hard-wired zero register), WAIT_W (width of
//           the starvation counter, covers MAX_WAIT up to 15).
package regfile_sched_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_MDU  = 2'd2
    } grant_e;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Purpose : pending-destination scoreboard for in-flight MDU ops plus the
//           decode hazard compare.
// Latency : pending updates at the posedge after issue/retire; hazard is
//           combinational from the registered pending vector.
// Backpr. : none itself; hazard tells decode to stall.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           issue, issue_reg    - MDU dispatch marks a destination pending
//           retire, retire_reg  - MDU result accepted, clears the destination
//           rd_reg1, rd_reg2    - decode sources
//           id_dst_valid/_reg   - decode destination (WAW check)
//           pending             - registered scoreboard, bit 0 always 0
//           hazard              - decode must stall
//           err                 - one-cycle protocol error pulse
module regfile_scoreboard
    import regfile_sched_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue,
    input  logic [ADDR_W-1:0]   issue_reg,
    input  logic                retire,
    input  logic [ADDR_W-1:0]   retire_reg,
    input  logic [ADDR_W-1:0]   rd_reg1,
    input  logic [ADDR_W-1:0]   rd_reg2,
    input  logic                id_dst_valid,
    input  logic [ADDR_W-1:0]   id_dst_reg,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard,
    output logic                err
);

    logic [NUM_REGS-1:0] pend_nxt;
    logic                issue_nz;
    logic                retire_nz;
    logic                same_reg;

    assign issue_nz  = issue && (int'(issue_reg) != REG_ZERO);
    assign retire_nz = retire && (int'(retire_reg) != REG_ZERO);
    assign same_reg  = retire && (retire_reg == issue_reg);

    // Clear first, then set, so a reissue of the retiring register wins.
    always_comb begin
        pend_nxt = pending;
        if (retire) pend_nxt[retire_reg] = 1'b0;
        if (issue)  pend_nxt[issue_reg]  = 1'b1;
        pend_nxt[REG_ZERO] = 1'b0;
    end

    // A reissue into a register retiring in the same cycle is legal.
    assign err = (issue_nz && pending[issue_reg] && !same_reg) ||
                 (retire_nz && !pending[retire_reg]);

    // Registered pending only: the stall persists through the write cycle.
    assign hazard = pending[rd_reg1] | pending[rd_reg2] |
                    (id_dst_valid & pending[id_dst_reg]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Purpose : owns the single register-file write port; arbitrates WB vs MDU,
//           bounds MDU starvation, tracks pending MDU destinations.
// Latency : zero - the write port is driven combinationally from the grant.
// Backpr. : WB held via wb_stall while the MDU is forced; MDU via mdu_ready.
// Ports   : wb_* (writeback result), mdu_issue* (dispatch), mdu_valid/ready/
//           reg/data (result handshake), rd_reg1/2 + id_dst_* (decode),
//           hazard_stall, rf_* (write port), pending, sched_err (sticky).
//           Optional REGFILE_SCHED_STATS_EN adds saturating stat_* counters.
module regfile_write_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                mdu_issue,
    input  logic [ADDR_W-1:0]   mdu_issue_reg,
    input  logic                mdu_valid,
    output logic                mdu_ready,
    input  logic [ADDR_W-1:0]   mdu_reg,
    input  logic [DATA_W-1:0]   mdu_data,
    input  logic [ADDR_W-1:0]   rd_reg1,
    input  logic [ADDR_W-1:0]   rd_reg2,
    input  logic                id_dst_valid,
    input  logic [ADDR_W-1:0]   id_dst_reg,
    output logic                hazard_stall,
    output logic                wb_stall,
    output logic                rf_regWrite,
    output logic [ADDR_W-1:0]   rf_writeReg,
    output logic [DATA_W-1:0]   rf_writeData,
    output logic [NUM_REGS-1:0] pending,
    output logic                sched_err
`ifdef REGFILE_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_wb_writes,
    output logic [31:0]         stat_mdu_writes,
    output logic [31:0]         stat_conflicts,
    output logic [31:0]         stat_forced
`endif
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    state_e            state;
    grant_e            grant;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wb_acc;
    logic              mdu_acc;
    logic              conflict;
    logic              force_entry;
    logic              force_viol;
    logic              sb_hazard;
    logic              sb_err;

    always_comb begin
        grant = GRANT_NONE;
        if (state == FORCE) begin
            if (mdu_valid) grant = GRANT_MDU;
        end else if (wb_valid) begin
            grant = GRANT_WB;
        end else if (mdu_valid) begin
            grant = GRANT_MDU;
        end
    end

    assign wb_acc   = !reset && (grant == GRANT_WB);
    assign mdu_acc  = !reset && (grant == GRANT_MDU);
    assign conflict = !reset && wb_valid && mdu_valid;

    // Entering FORCE when this lost cycle brings the count to MAX_WAIT, so
    // the MDU wins on the very next cycle.
    assign force_entry = (state == NORMAL) && conflict && (wait_cnt >= MAX_CNT - 1'b1);
    assign force_viol  = !reset && (state == FORCE) && !mdu_valid;

    assign mdu_ready    = mdu_acc;
    assign wb_stall     = !reset && wb_valid && (state == FORCE);
    assign hazard_stall = !reset && sb_hazard;

    // Write mux; the handshake still completes for reg 0, only the enable drops.
    assign rf_writeReg  = mdu_acc ? mdu_reg  : wb_reg;
    assign rf_writeData = mdu_acc ? mdu_data : wb_data;
    assign rf_regWrite  = (wb_acc || mdu_acc) && (int'(rf_writeReg) != REG_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= NORMAL;
            wait_cnt  <= '0;
            sched_err <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (mdu_acc) begin
                        wait_cnt <= '0;
                    end else if (conflict) begin
                        if (wait_cnt < MAX_CNT) wait_cnt <= wait_cnt + 1'b1;
                        if (force_entry) state <= FORCE;
                    end
                end
                FORCE: begin
                    // Either the MDU is accepted or it dropped valid (error);
                    // both return to fair arbitration.
                    state    <= NORMAL;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= NORMAL;
                    wait_cnt <= '0;
                end
            endcase
            if (sb_err || force_viol) sched_err <= 1'b1;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue        (mdu_issue),
        .issue_reg    (mdu_issue_reg),
        .retire       (mdu_acc),
        .retire_reg   (mdu_reg),
        .rd_reg1      (rd_reg1),
        .rd_reg2      (rd_reg2),
        .id_dst_valid (id_dst_valid),
        .id_dst_reg   (id_dst_reg),
        .pending      (pending),
        .hazard       (sb_hazard),
        .err          (sb_err)
    );

`ifdef REGFILE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wb_writes  <= '0;
            stat_mdu_writes <= '0;
            stat_conflicts  <= '0;
            stat_forced     <= '0;
        end else begin
            if (wb_acc && stat_wb_writes != '1)   stat_wb_writes  <= stat_wb_writes + 1'b1;
            if (mdu_acc && stat_mdu_writes != '1) stat_mdu_writes <= stat_mdu_writes + 1'b1;
            if (conflict && stat_conflicts != '1) stat_conflicts  <= stat_conflicts + 1'b1;
            if (force_entry && stat_forced != '1) stat_forced     <= stat_forced + 1'b1;
        end
    end
`endif

endmodule
